// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-port on-chip RAM between the CPU and the UART bootloader.
// One access per cycle, registered RAM strobes, read data routed back by a tag pipe.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot_en,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              boot_req,
    input  logic              boot_we,
    input  logic [ADDR_W-1:0] boot_addr,
    input  logic [DATA_W-1:0] boot_wdata,
    output logic              boot_gnt,
    output logic              boot_rvalid,
    output logic [DATA_W-1:0] boot_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_do
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

    typedef enum logic [1:0] {StIdle, StCpu, StBoot} state_e;

    state_e            state_q, state_d;
    logic              last_boot_q, last_boot_d;
    logic [CntW-1:0]   burst_cnt_q, burst_cnt_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_di_q, ram_di_d;
    logic [RD_LAT:0]   tag_vld_q, tag_vld_d;
    logic [RD_LAT:0]   tag_boot_q, tag_boot_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] boot_rdata_q, boot_rdata_d;
    logic              grant_cpu, grant_boot, grant_any, grant_rd;

    // Grants are gated by rst so every output reads 0 while reset is held.
    always_comb begin
        grant_cpu  = 1'b0;
        grant_boot = 1'b0;
        if (!rst) begin
            if (cpu_req && boot_req) begin
                if (boot_en) begin
                    if (state_q == StBoot && burst_cnt_q >= CntMax) grant_cpu = 1'b1;
                    else                                            grant_boot = 1'b1;
                end else if (last_boot_q) begin
                    grant_cpu = 1'b1;
                end else begin
                    grant_boot = 1'b1;
                end
            end else begin
                grant_cpu  = cpu_req;
                grant_boot = boot_req;
            end
        end
    end

    assign grant_any = grant_cpu | grant_boot;
    assign grant_rd  = (grant_cpu & ~cpu_we) | (grant_boot & ~boot_we);

    always_comb begin
        state_d     = StIdle;
        last_boot_d = last_boot_q;
        burst_cnt_d = '0;
        if (grant_any) begin
            state_d     = grant_boot ? StBoot : StCpu;
            last_boot_d = grant_boot;
            if (grant_boot == last_boot_q) begin
                burst_cnt_d = (burst_cnt_q == CntMax) ? burst_cnt_q : burst_cnt_q + 1'b1;
            end else begin
                burst_cnt_d = CntW'(1);
            end
        end

        ram_en_d   = grant_any;
        ram_we_d   = grant_cpu ? cpu_we : (grant_boot & boot_we);
        ram_addr_d = grant_cpu ? cpu_addr : (grant_boot ? boot_addr : ram_addr_q);
        ram_di_d   = grant_cpu ? cpu_wdata : (grant_boot ? boot_wdata : ram_di_q);

        // Stage k is aligned with the cycle k after ram_en; stage RD_LAT meets ram_do.
        tag_vld_d  = {tag_vld_q[RD_LAT-1:0], grant_rd};
        tag_boot_d = {tag_boot_q[RD_LAT-1:0], grant_boot};
    end

    assign cpu_rvalid  = tag_vld_q[RD_LAT] & ~tag_boot_q[RD_LAT];
    assign boot_rvalid = tag_vld_q[RD_LAT] & tag_boot_q[RD_LAT];

    // Pass ram_do through on the rvalid cycle, then hold it until the next rvalid.
    always_comb begin
        cpu_rdata_d  = cpu_rvalid ? ram_do : cpu_rdata_q;
        boot_rdata_d = boot_rvalid ? ram_do : boot_rdata_q;
    end

    assign cpu_rdata  = cpu_rdata_d;
    assign boot_rdata = boot_rdata_d;
    assign cpu_gnt    = grant_cpu;
    assign boot_gnt   = grant_boot;
    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_di     = ram_di_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_boot_q  <= 1'b1;
            burst_cnt_q  <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_di_q     <= '0;
            tag_vld_q    <= '0;
            tag_boot_q   <= '0;
            cpu_rdata_q  <= '0;
            boot_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_boot_q  <= last_boot_d;
            burst_cnt_q  <= burst_cnt_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_di_q     <= ram_di_d;
            tag_vld_q    <= tag_vld_d;
            tag_boot_q   <= tag_boot_d;
            cpu_rdata_q  <= cpu_rdata_d;
            boot_rdata_q <= boot_rdata_d;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed vector table plus reset and randomised scoreboard sequences for ram_port_arbiter.
module tb_ram_port_arbiter;

    localparam int unsigned RD_LAT    = 1;
    localparam int unsigned MAX_BURST = 4;
    localparam logic [12:0] CA = 13'h100;
    localparam logic [7:0]  CD = 8'hC1;
    localparam logic [12:0] BA = 13'h200;
    localparam logic [7:0]  BD = 8'hB2;

    logic        clk = 1'b0;
    logic        rst;
    logic        boot_en;
    logic        cpu_req, cpu_we, boot_req, boot_we;
    logic [12:0] cpu_addr, boot_addr;
    logic [7:0]  cpu_wdata, boot_wdata;
    logic        cpu_gnt, cpu_rvalid, boot_gnt, boot_rvalid;
    logic [7:0]  cpu_rdata, boot_rdata;
    logic        ram_en, ram_we;
    logic [12:0] ram_addr;
    logic [7:0]  ram_di, ram_do;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .ADDR_W(13), .DATA_W(8), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst), .boot_en(boot_en),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .boot_req(boot_req), .boot_we(boot_we), .boot_addr(boot_addr),
        .boot_wdata(boot_wdata), .boot_gnt(boot_gnt), .boot_rvalid(boot_rvalid),
        .boot_rdata(boot_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
        .ram_do(ram_do)
    );

    // Synchronous RAM model: read-first, data appears RD_LAT cycles after ram_en.
    logic [7:0] mem [0:8191];
    logic [7:0] rd_pipe [0:RD_LAT-1];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
            mem[13'h010] <= 8'h11;
            mem[13'h020] <= 8'h22;
            for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= 8'h00;
        end else begin
            rd_pipe[0] <= mem[ram_addr];
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
            if (ram_en && ram_we) mem[ram_addr] <= ram_di;
        end
    end
    assign ram_do = rd_pipe[RD_LAT-1];

    typedef struct {
        logic be, cr, cw; logic [12:0] ca; logic [7:0] cd;
        logic br, bw;     logic [12:0] ba; logic [7:0] bd;
        logic cg, bg, en, we; logic [12:0] addr; logic [7:0] di;
        logic crv; logic [7:0] crd; logic brv; logic [7:0] brd;
    } vec_t;

    function automatic vec_t v(
        input logic be, cr, cw, input logic [12:0] ca, input logic [7:0] cd,
        input logic br, bw, input logic [12:0] ba, input logic [7:0] bd,
        input logic cg, bg, en, we, input logic [12:0] addr, input logic [7:0] di,
        input logic crv, input logic [7:0] crd, input logic brv, input logic [7:0] brd);
        vec_t r;
        r.be = be; r.cr = cr; r.cw = cw; r.ca = ca; r.cd = cd;
        r.br = br; r.bw = bw; r.ba = ba; r.bd = bd;
        r.cg = cg; r.bg = bg; r.en = en; r.we = we; r.addr = addr; r.di = di;
        r.crv = crv; r.crd = crd; r.brv = brv; r.brd = brd;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    vec_t        tbl[$];
    logic [7:0]  ref_mem [0:15];
    logic [7:0]  cq[$];
    logic [7:0]  bq[$];
    logic [7:0]  exp_d;
    logic        c_done, b_done, ok;
    int          c_wait, b_wait, max_wait;

    initial begin
        rst = 1'b1; boot_en = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        boot_req = 0; boot_we = 0; boot_addr = '0; boot_wdata = '0;

        // be cr cw ca cd br bw ba bd | cg bg en we addr di crv crd brv brd
        tbl.push_back(v(0, 0,0,0,0,         0,0,0,0,         0,0, 0,0,0,0,         0,0,0,0));
        tbl.push_back(v(0, 1,1,13'h0A5,8'h3C, 0,0,0,0,       1,0, 0,0,0,0,         0,0,0,0));
        tbl.push_back(v(0, 1,0,13'h0A5,0,   0,0,0,0,         1,0, 1,1,13'h0A5,8'h3C, 0,0,0,0));
        tbl.push_back(v(0, 0,0,0,0,         0,0,0,0,         0,0, 1,0,13'h0A5,0,   0,0,0,0));
        tbl.push_back(v(0, 0,0,0,0,         0,0,0,0,         0,0, 0,0,0,0,         1,8'h3C,0,0));
        tbl.push_back(v(0, 0,0,0,0,         0,0,0,0,         0,0, 0,0,0,0,         0,0,0,0));
        tbl.push_back(v(0, 1,0,13'h010,0,   0,0,0,0,         1,0, 0,0,0,0,         0,0,0,0));
        tbl.push_back(v(0, 0,0,0,0,         1,0,13'h020,0,   0,1, 1,0,13'h010,0,   0,0,0,0));
        tbl.push_back(v(0, 0,0,0,0,         0,0,0,0,         0,0, 1,0,13'h020,0,   1,8'h11,0,0));
        tbl.push_back(v(0, 0,0,0,0,         0,0,0,0,         0,0, 0,0,0,0,         0,0,1,8'h22));
        for (int i = 0; i < 6; i++) begin
            tbl.push_back(v(0, 1,1,CA,CD, 1,1,BA,BD, i[0] == 0, i[0] == 1,
                            i != 0, i != 0, i[0] ? CA : BA, i[0] ? CD : BD, 0,0,0,0));
        end
        tbl.push_back(v(0, 0,0,0,0,         0,0,0,0,         0,0, 1,1,BA,BD,       0,0,0,0));
        // boot_en=1: B B B B C B B B B C
        tbl.push_back(v(1, 1,1,CA,CD, 1,1,BA,BD, 0,1, 0,0,0,0,   0,0,0,0));
        tbl.push_back(v(1, 1,1,CA,CD, 1,1,BA,BD, 0,1, 1,1,BA,BD, 0,0,0,0));
        tbl.push_back(v(1, 1,1,CA,CD, 1,1,BA,BD, 0,1, 1,1,BA,BD, 0,0,0,0));
        tbl.push_back(v(1, 1,1,CA,CD, 1,1,BA,BD, 0,1, 1,1,BA,BD, 0,0,0,0));
        tbl.push_back(v(1, 1,1,CA,CD, 1,1,BA,BD, 1,0, 1,1,BA,BD, 0,0,0,0));
        tbl.push_back(v(1, 1,1,CA,CD, 1,1,BA,BD, 0,1, 1,1,CA,CD, 0,0,0,0));
        tbl.push_back(v(1, 1,1,CA,CD, 1,1,BA,BD, 0,1, 1,1,BA,BD, 0,0,0,0));
        tbl.push_back(v(1, 1,1,CA,CD, 1,1,BA,BD, 0,1, 1,1,BA,BD, 0,0,0,0));
        tbl.push_back(v(1, 1,1,CA,CD, 1,1,BA,BD, 0,1, 1,1,BA,BD, 0,0,0,0));
        tbl.push_back(v(1, 1,1,CA,CD, 1,1,BA,BD, 1,0, 1,1,BA,BD, 0,0,0,0));
        tbl.push_back(v(1, 0,0,0,0,   0,0,0,0,   0,0, 1,1,CA,CD, 0,0,0,0));
        tbl.push_back(v(1, 0,0,0,0,   0,0,0,0,   0,0, 0,0,0,0,   0,0,0,0));
        tbl.push_back(v(1, 1,1,CA,CD, 0,0,0,0,   1,0, 0,0,0,0,   0,0,0,0));
        tbl.push_back(v(0, 0,0,0,0,   0,0,0,0,   0,0, 1,1,CA,CD, 0,0,0,0));

        tick(); tick();
        chk("reset_outputs",
            {cpu_gnt, boot_gnt, cpu_rvalid, boot_rvalid, ram_en, ram_we, ram_addr, ram_di,
             cpu_rdata, boot_rdata}, '0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            tick();
            boot_en = tbl[i].be;
            cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cd;
            boot_req = tbl[i].br; boot_we = tbl[i].bw; boot_addr = tbl[i].ba;
            boot_wdata = tbl[i].bd;
            #1;
            ok = cpu_gnt === tbl[i].cg && boot_gnt === tbl[i].bg && ram_en === tbl[i].en &&
                 ram_we === tbl[i].we && cpu_rvalid === tbl[i].crv &&
                 boot_rvalid === tbl[i].brv &&
                 (!tbl[i].en || (ram_addr === tbl[i].addr && ram_di === tbl[i].di)) &&
                 (!tbl[i].crv || cpu_rdata === tbl[i].crd) &&
                 (!tbl[i].brv || boot_rdata === tbl[i].brd);
            n_vec++;
            if (!ok) begin
                n_fail++;
                $display("FAIL vec%0d: got gnt=%b%b en=%b we=%b addr=%h di=%h rv=%b%b rd=%h/%h want gnt=%b%b en=%b we=%b addr=%h di=%h rv=%b%b rd=%h/%h",
                         i, cpu_gnt, boot_gnt, ram_en, ram_we, ram_addr, ram_di, cpu_rvalid,
                         boot_rvalid, cpu_rdata, boot_rdata, tbl[i].cg, tbl[i].bg, tbl[i].en,
                         tbl[i].we, tbl[i].addr, tbl[i].di, tbl[i].crv, tbl[i].brv,
                         tbl[i].crd, tbl[i].brd);
            end
        end

        // Reset one cycle after a CPU read grant drops the in-flight read.
        tick();
        boot_en = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 13'h010;
        #1 chk("rst_pre_gnt", cpu_gnt, 1);
        tick();
        cpu_req = 0; rst = 1;
        #1 chk("rst_outputs_zero",
               {cpu_gnt, boot_gnt, cpu_rvalid, boot_rvalid, ram_en, ram_we, ram_addr, ram_di,
                cpu_rdata, boot_rdata}, '0);
        tick();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("rst_no_rvalid", {cpu_rvalid, boot_rvalid}, 0);
            tick();
        end
        cpu_req = 1; cpu_we = 1; cpu_addr = CA; boot_req = 1; boot_we = 1; boot_addr = BA;
        #1 chk("rst_first_gnt_cpu", {cpu_gnt, boot_gnt}, 2'b10);
        tick();
        cpu_req = 0; boot_req = 0;
        tick(); tick();

        // Randomised traffic against a reference memory.
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        c_done = 1; b_done = 1; c_wait = 0; b_wait = 0; max_wait = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (cyc % 97 == 0) boot_en = ~boot_en;
            if (c_done) begin
                cpu_req = ($urandom % 4) != 0; cpu_we = $urandom % 2;
                cpu_addr = 13'h1F00 | 13'($urandom % 16); cpu_wdata = 8'($urandom);
            end
            if (b_done) begin
                boot_req = ($urandom % 4) != 0; boot_we = $urandom % 2;
                boot_addr = 13'h1F00 | 13'($urandom % 16); boot_wdata = 8'($urandom);
            end
            #1;
            chk("gnt_legal", {cpu_gnt & boot_gnt, cpu_gnt & ~cpu_req, boot_gnt & ~boot_req}, 0);
            if (cpu_rvalid) begin
                exp_d = (cq.size() != 0) ? cq.pop_front() : 8'hxx;
                chk("rnd_cpu_rdata", {cq.size() >= 0, cpu_rdata}, {1'b1, exp_d});
            end
            if (boot_rvalid) begin
                exp_d = (bq.size() != 0) ? bq.pop_front() : 8'hxx;
                chk("rnd_boot_rdata", {1'b1, boot_rdata}, {1'b1, exp_d});
            end
            if (cpu_gnt) begin
                if (cpu_we) ref_mem[cpu_addr[3:0]] = cpu_wdata;
                else        cq.push_back(ref_mem[cpu_addr[3:0]]);
            end
            if (boot_gnt) begin
                if (boot_we) ref_mem[boot_addr[3:0]] = boot_wdata;
                else         bq.push_back(ref_mem[boot_addr[3:0]]);
            end
            c_wait = (cpu_req && !cpu_gnt) ? c_wait + 1 : 0;
            b_wait = (boot_req && !boot_gnt) ? b_wait + 1 : 0;
            if (c_wait > max_wait) max_wait = c_wait;
            if (b_wait > max_wait) max_wait = b_wait;
            c_done = !cpu_req || cpu_gnt;
            b_done = !boot_req || boot_gnt;
        end
        tick();
        cpu_req = 0; boot_req = 0;
        for (int i = 0; i < RD_LAT + 3; i++) begin
            #1;
            if (cpu_rvalid) begin
                exp_d = (cq.size() != 0) ? cq.pop_front() : 8'hxx;
                chk("drain_cpu_rdata", {1'b1, cpu_rdata}, {1'b1, exp_d});
            end
            if (boot_rvalid) begin
                exp_d = (bq.size() != 0) ? bq.pop_front() : 8'hxx;
                chk("drain_boot_rdata", {1'b1, boot_rdata}, {1'b1, exp_d});
            end
            tick();
        end
        chk("reads_all_returned", {32'(cq.size()), 32'(bq.size())}, 0);
        chk("no_starvation", max_wait > MAX_BURST, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
